// File: rtl/wb_wrbuf.sv
// -----------------------------------------------------------------------------
// wb_wrbuf -- posted-write buffer between a cache's Wishbone master side and
// the memory bus.
//
// Writes from the cache are pushed into a DEPTH-entry FIFO and acknowledged on
// the following cycle. The FIFO drains to memory in the background. A read is
// parked in a holding register until every earlier write has completed
// downstream, so memory sees requests in program order.
//
// Parameters
//   ARCHBITSZ  data width in bits (16/32/64/128/256)
//   DEPTH      FIFO entries, power of two, >= 2
//
// Ports
//   clk_i, rst_i          clock (posedge) and asynchronous active-low reset
//   m_wb_cyc_i/stb_i      upstream request, valid when both are high
//   m_wb_we_i             1 = write, 0 = read
//   m_wb_addr_i/sel_i     word address and byte selects
//   m_wb_dat_i            write data
//   m_wb_bsy_o            request cannot be accepted this cycle (combinational)
//   m_wb_ack_o            single-cycle completion pulse
//   m_wb_dat_o            read data, valid together with a read's ack
//   s_wb_cyc_o/stb_o/we_o downstream cycle, strobe and write enable
//   s_wb_addr_o/sel_o     downstream address and byte selects
//   s_wb_dat_o            downstream write data
//   s_wb_bsy_i            downstream cannot take the strobe this cycle
//   s_wb_ack_i            downstream completion
//   s_wb_dat_i            downstream read data
//   empty_o               nothing buffered, no read parked, bus idle
// -----------------------------------------------------------------------------
module wb_wrbuf #(
   parameter  int ARCHBITSZ = 16,
   parameter  int DEPTH     = 4,
   localparam int SELBITSZ  = ARCHBITSZ / 8,
   localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,

   input  logic                 m_wb_cyc_i,
   input  logic                 m_wb_stb_i,
   input  logic                 m_wb_we_i,
   input  logic [ADDRBITSZ-1:0] m_wb_addr_i,
   input  logic [SELBITSZ-1:0]  m_wb_sel_i,
   input  logic [ARCHBITSZ-1:0] m_wb_dat_i,
   output logic                 m_wb_bsy_o,
   output logic                 m_wb_ack_o,
   output logic [ARCHBITSZ-1:0] m_wb_dat_o,

   output logic                 s_wb_cyc_o,
   output logic                 s_wb_stb_o,
   output logic                 s_wb_we_o,
   output logic [ADDRBITSZ-1:0] s_wb_addr_o,
   output logic [SELBITSZ-1:0]  s_wb_sel_o,
   output logic [ARCHBITSZ-1:0] s_wb_dat_o,
   input  logic                 s_wb_bsy_i,
   input  logic                 s_wb_ack_i,
   input  logic [ARCHBITSZ-1:0] s_wb_dat_i,

   output logic                 empty_o
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;
   localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WR   = 2'd1;
   localparam logic [1:0] ST_RD   = 2'd2;

   // FIFO storage
   logic [ADDRBITSZ-1:0] fifo_addr [DEPTH];
   logic [SELBITSZ-1:0]  fifo_sel  [DEPTH];
   logic [ARCHBITSZ-1:0] fifo_dat  [DEPTH];

   logic [PTRW-1:0]      wr_ptr;
   logic [PTRW-1:0]      rd_ptr;
   logic [CNTW-1:0]      count;

   // Read holding register
   logic                 rd_pend;
   logic [ADDRBITSZ-1:0] rd_addr;
   logic [SELBITSZ-1:0]  rd_sel;

   logic [1:0]           state;

   logic                 req;
   logic                 push;
   logic                 rd_acc;
   logic                 pop;
   logic                 rd_done;
   logic                 issue_wr;
   logic                 issue_rd;

   // Request acceptance and drain decisions
   always_comb begin
      req = m_wb_cyc_i && m_wb_stb_i;

      // Busy is decided from pre-edge state only, so a full FIFO refuses a
      // write even on the edge where the head entry is popped.
      if (!rst_i)
         m_wb_bsy_o = 1'b1;
      else if (m_wb_we_i)
         m_wb_bsy_o = (count == CNT_FULL) || rd_pend;
      else
         m_wb_bsy_o = rd_pend;

      push    = req && m_wb_we_i  && !m_wb_bsy_o;
      rd_acc  = req && !m_wb_we_i && !m_wb_bsy_o;

      // Acks are only meaningful while a downstream cycle is owned.
      pop     = (state == ST_WR) && s_wb_ack_i;
      rd_done = (state == ST_RD) && s_wb_ack_i;

      // Buffered writes always go before the parked read.
      issue_wr = (state == ST_IDLE) && (count != '0);
      issue_rd = (state == ST_IDLE) && (count == '0) && rd_pend;

      empty_o  = (count == '0) && !rd_pend && !s_wb_cyc_o;
   end

   // Control state: pointers, occupancy, read-pending flag, bus FSM
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rd_pend    <= 1'b0;
         state      <= ST_IDLE;
         s_wb_cyc_o <= 1'b0;
         s_wb_stb_o <= 1'b0;
         s_wb_we_o  <= 1'b0;
         m_wb_ack_o <= 1'b0;
         m_wb_dat_o <= '0;
      end else begin
         // Posted writes complete upstream immediately; reads complete when
         // memory answers.
         m_wb_ack_o <= push || rd_done;

         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (rd_acc)
            rd_pend <= 1'b1;
         else if (rd_done)
            rd_pend <= 1'b0;

         if (rd_done)
            m_wb_dat_o <= s_wb_dat_i;

         case (state)
            ST_IDLE: begin
               if (issue_wr) begin
                  s_wb_cyc_o <= 1'b1;
                  s_wb_stb_o <= 1'b1;
                  s_wb_we_o  <= 1'b1;
                  state      <= ST_WR;
               end else if (issue_rd) begin
                  s_wb_cyc_o <= 1'b1;
                  s_wb_stb_o <= 1'b1;
                  s_wb_we_o  <= 1'b0;
                  state      <= ST_RD;
               end
            end
            ST_WR, ST_RD: begin
               // Strobe is one-shot: dropped once memory has taken it, while
               // cyc stays up until the ack.
               if (s_wb_stb_o && !s_wb_bsy_i)
                  s_wb_stb_o <= 1'b0;
               if (s_wb_ack_i) begin
                  s_wb_cyc_o <= 1'b0;
                  s_wb_stb_o <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               s_wb_cyc_o <= 1'b0;
               s_wb_stb_o <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

   // Datapath: FIFO contents, read holding register, downstream address/data.
   // These carry no reset; every consumer is qualified by the control state.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_addr[wr_ptr] <= m_wb_addr_i;
         fifo_sel[wr_ptr]  <= m_wb_sel_i;
         fifo_dat[wr_ptr]  <= m_wb_dat_i;
      end

      if (rd_acc) begin
         rd_addr <= m_wb_addr_i;
         rd_sel  <= m_wb_sel_i;
      end

      // Loaded only when a new downstream cycle starts, so the bus stays
      // stable for the whole transfer.
      if (issue_wr) begin
         s_wb_addr_o <= fifo_addr[rd_ptr];
         s_wb_sel_o  <= fifo_sel[rd_ptr];
         s_wb_dat_o  <= fifo_dat[rd_ptr];
      end else if (issue_rd) begin
         s_wb_addr_o <= rd_addr;
         s_wb_sel_o  <= rd_sel;
      end
   end

endmodule

// File: tb/tb_wb_wrbuf.sv
// -----------------------------------------------------------------------------
// tb_wb_wrbuf -- self-checking bench for wb_wrbuf (ARCHBITSZ=16, DEPTH=4).
//
// A behavioural model tracks outstanding requests as plain counters/queues:
// the downstream request stream must equal the upstream acceptance order, the
// read data must equal a program-order memory image, and busy/ack/empty follow
// from the number of buffered writes and whether a read is parked. A bench
// memory answers the downstream bus one cycle after it takes a strobe.
// -----------------------------------------------------------------------------
module tb_wb_wrbuf;

   localparam int DW    = 16;
   localparam int SW    = 2;
   localparam int AW    = 15;
   localparam int DEPTH = 4;

   logic          clk_i;
   logic          rst_i;
   logic          m_wb_cyc_i;
   logic          m_wb_stb_i;
   logic          m_wb_we_i;
   logic [AW-1:0] m_wb_addr_i;
   logic [SW-1:0] m_wb_sel_i;
   logic [DW-1:0] m_wb_dat_i;
   logic          m_wb_bsy_o;
   logic          m_wb_ack_o;
   logic [DW-1:0] m_wb_dat_o;
   logic          s_wb_cyc_o;
   logic          s_wb_stb_o;
   logic          s_wb_we_o;
   logic [AW-1:0] s_wb_addr_o;
   logic [SW-1:0] s_wb_sel_o;
   logic [DW-1:0] s_wb_dat_o;
   logic          s_wb_bsy_i;
   logic          s_wb_ack_i;
   logic [DW-1:0] s_wb_dat_i;
   logic          empty_o;

   wb_wrbuf #(.ARCHBITSZ(DW), .DEPTH(DEPTH)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .m_wb_cyc_i  (m_wb_cyc_i),
      .m_wb_stb_i  (m_wb_stb_i),
      .m_wb_we_i   (m_wb_we_i),
      .m_wb_addr_i (m_wb_addr_i),
      .m_wb_sel_i  (m_wb_sel_i),
      .m_wb_dat_i  (m_wb_dat_i),
      .m_wb_bsy_o  (m_wb_bsy_o),
      .m_wb_ack_o  (m_wb_ack_o),
      .m_wb_dat_o  (m_wb_dat_o),
      .s_wb_cyc_o  (s_wb_cyc_o),
      .s_wb_stb_o  (s_wb_stb_o),
      .s_wb_we_o   (s_wb_we_o),
      .s_wb_addr_o (s_wb_addr_o),
      .s_wb_sel_o  (s_wb_sel_o),
      .s_wb_dat_o  (s_wb_dat_o),
      .s_wb_bsy_i  (s_wb_bsy_i),
      .s_wb_ack_i  (s_wb_ack_i),
      .s_wb_dat_i  (s_wb_dat_i),
      .empty_o     (empty_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [SW-1:0] sel;
      logic [DW-1:0] dat;
   } txn_t;

   int total = 0;
   int bad   = 0;

   // model state
   txn_t          exp_q[$];
   logic [AW-1:0] log_addr[$];
   logic          log_we[$];
   bit [DW-1:0]   slv_mem [256];
   bit [DW-1:0]   ref_mem [256];
   int            pend_wr = 0;
   bit            rdp     = 1'b0;
   bit            cur_we  = 1'b0;
   bit            ack_exp = 1'b0;
   bit            ack_rd  = 1'b0;
   logic [DW-1:0] rd_exp  = '0;
   int            ack_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timeout got 0 want 1", nm);
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [SW-1:0] sel,
                                           input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = old;
      if (sel[0]) r[7:0]  = d[7:0];
      if (sel[1]) r[15:8] = d[15:8];
      return r;
   endfunction

   // Model update and downstream memory responder (pre-edge values at posedge)
   initial begin
      bit            nack;
      logic [DW-1:0] ndat;
      txn_t          e;
      s_wb_ack_i = 1'b0;
      s_wb_dat_i = '0;
      forever begin
         @(posedge clk_i);
         nack = 1'b0;
         ndat = s_wb_dat_i;
         if (!rst_i) begin
            exp_q.delete();
            pend_wr = 0;
            rdp     = 1'b0;
            ack_exp = 1'b0;
            ack_rd  = 1'b0;
            ref_mem = slv_mem;
         end else begin
            ack_exp = 1'b0;
            ack_rd  = 1'b0;
            if (s_wb_ack_i) begin
               if (cur_we) pend_wr--;
               else begin
                  rdp     = 1'b0;
                  ack_exp = 1'b1;
                  ack_rd  = 1'b1;
               end
            end
            if (m_wb_cyc_i && m_wb_stb_i && !m_wb_bsy_o) begin
               e.we   = m_wb_we_i;
               e.addr = m_wb_addr_i;
               e.sel  = m_wb_sel_i;
               e.dat  = m_wb_dat_i;
               exp_q.push_back(e);
               if (m_wb_we_i) begin
                  ref_mem[m_wb_addr_i[7:0]] = merge(ref_mem[m_wb_addr_i[7:0]], m_wb_sel_i, m_wb_dat_i);
                  pend_wr++;
                  ack_exp = 1'b1;
               end else begin
                  rdp    = 1'b1;
                  rd_exp = ref_mem[m_wb_addr_i[7:0]];
               end
            end
            if (s_wb_cyc_o && s_wb_stb_o && !s_wb_bsy_i) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL dn_unexpected: got addr %0h want none", s_wb_addr_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("dn_we",   32'(s_wb_we_o),   32'(e.we));
                  chk("dn_addr", 32'(s_wb_addr_o), 32'(e.addr));
                  chk("dn_sel",  32'(s_wb_sel_o),  32'(e.sel));
                  if (e.we) chk("dn_dat", 32'(s_wb_dat_o), 32'(e.dat));
               end
               log_addr.push_back(s_wb_addr_o);
               log_we.push_back(s_wb_we_o);
               cur_we = s_wb_we_o;
               if (s_wb_we_o)
                  slv_mem[s_wb_addr_o[7:0]] = merge(slv_mem[s_wb_addr_o[7:0]], s_wb_sel_o, s_wb_dat_o);
               else
                  ndat = slv_mem[s_wb_addr_o[7:0]];
               nack = 1'b1;
            end
         end
         #1;
         s_wb_ack_i = nack;
         s_wb_dat_i = ndat;
      end
   end

   // Per-cycle compare against the model
   initial begin
      bit            pcyc;
      logic          pwe;
      logic [AW-1:0] paddr;
      logic [SW-1:0] psel;
      logic [DW-1:0] pdat;
      pcyc = 1'b0;
      forever begin
         @(negedge clk_i);
         if (m_wb_ack_o) ack_cnt++;
         if (!rst_i) begin
            chk("rst_bsy",   32'(m_wb_bsy_o), 32'd1);
            chk("rst_cyc",   32'(s_wb_cyc_o), 32'd0);
            chk("rst_ack",   32'(m_wb_ack_o), 32'd0);
            chk("rst_empty", 32'(empty_o),    32'd1);
            pcyc = 1'b0;
         end else begin
            chk("bsy", 32'(m_wb_bsy_o),
                32'(m_wb_we_i ? ((pend_wr == DEPTH) || rdp) : rdp));
            chk("empty", 32'(empty_o), 32'((pend_wr == 0) && !rdp));
            chk("ack",   32'(m_wb_ack_o), 32'(ack_exp));
            if (ack_exp && ack_rd) chk("rdata", 32'(m_wb_dat_o), 32'(rd_exp));
            if (pcyc && s_wb_cyc_o) begin
               chk("hold_we",   32'(s_wb_we_o),   32'(pwe));
               chk("hold_addr", 32'(s_wb_addr_o), 32'(paddr));
               chk("hold_sel",  32'(s_wb_sel_o),  32'(psel));
               chk("hold_dat",  32'(s_wb_dat_o),  32'(pdat));
            end
            pcyc  = s_wb_cyc_o;
            pwe   = s_wb_we_o;
            paddr = s_wb_addr_o;
            psel  = s_wb_sel_o;
            pdat  = s_wb_dat_o;
         end
      end
   end

   task automatic wait_accept(input string nm, output int n);
      bit acc;
      n = 0;
      forever begin
         @(negedge clk_i);
         acc = (m_wb_bsy_o == 1'b0);
         @(posedge clk_i);
         #1;
         if (acc) break;
         n++;
         if (n > 200) begin
            fail_now(nm);
            break;
         end
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d,
                     output int n);
      m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = 1'b1;
      m_wb_addr_i = a;   m_wb_sel_i = s;    m_wb_dat_i = d;
      wait_accept("wr_accept", n);
      m_wb_cyc_i = 1'b0; m_wb_stb_i = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [SW-1:0] s, output int n);
      m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = 1'b0;
      m_wb_addr_i = a;   m_wb_sel_i = s;
      wait_accept("rd_accept", n);
      m_wb_cyc_i = 1'b0; m_wb_stb_i = 1'b0;
   endtask

   task automatic wait_ack(input string nm, output int lat);
      lat = 0;
      forever begin
         @(negedge clk_i);
         if (m_wb_ack_o) break;
         lat++;
         if (lat > 200) begin
            fail_now(nm);
            break;
         end
      end
   endtask

   task automatic wait_empty(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!(empty_o === 1'b1 && exp_q.size() == 0) && n < 300);
      if (n >= 300) fail_now(nm);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lat, base, L;
      bit seen, got;
      for (int i = 0; i < 256; i++) begin
         slv_mem[i] = 16'hA000 + 16'(i);
         ref_mem[i] = 16'hA000 + 16'(i);
      end
      rst_i = 1'b0;
      m_wb_cyc_i = 1'b0; m_wb_stb_i = 1'b0; m_wb_we_i = 1'b0;
      m_wb_addr_i = '0;  m_wb_sel_i = '0;   m_wb_dat_i = '0;
      s_wb_bsy_i = 1'b0;

      // reset state
      repeat (3) @(negedge clk_i);
      chk("rst_mdat",   32'(m_wb_dat_o), 32'd0);
      chk("rst_swe",    32'(s_wb_we_o),  32'd0);
      chk("rst_empty0", 32'(empty_o),    32'd1);
      chk("rst_bsy0",   32'(m_wb_bsy_o), 32'd1);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // 1: fill with memory stalled, fifth write refused until first pop
      s_wb_bsy_i = 1'b1;
      base = ack_cnt;
      for (int i = 0; i < 4; i++) begin
         wr(15'h40 + 15'(i), 2'b11, 16'h1100 + 16'(i), n);
         chk("t1_no_wait", 32'(n), 32'd0);
      end
      @(negedge clk_i);
      chk("t1_acks", 32'(ack_cnt - base), 32'd4);
      m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = 1'b1;
      m_wb_addr_i = 15'h44; m_wb_sel_i = 2'b11; m_wb_dat_i = 16'h1104;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk("t1_full_bsy", 32'(m_wb_bsy_o), 32'd1);
      end
      @(posedge clk_i);
      #1 s_wb_bsy_i = 1'b0;
      wait_accept("t1_fifth", n);
      m_wb_cyc_i = 1'b0; m_wb_stb_i = 1'b0;
      chk("t1_fifth_wait", 32'(n), 32'd2);
      wait_empty("t1_drain");

      // 2: write then read same address, order and forwarded data
      wr(15'h10, 2'b11, 16'hBEEF, n);
      rd(15'h10, 2'b11, n);
      wait_ack("t2_ack", lat);
      chk("t2_rdata", 32'(m_wb_dat_o), 32'hBEEF);
      wait_empty("t2_drain");
      L = log_addr.size();
      chk("t2_first_addr", 32'(log_addr[L-2]), 32'h10);
      chk("t2_first_we",   32'(log_we[L-2]),   32'd1);
      chk("t2_second_addr", 32'(log_addr[L-1]), 32'h10);
      chk("t2_second_we",   32'(log_we[L-1]),   32'd0);

      // 3: read latency with empty FIFO
      rd(15'h05, 2'b11, n);
      chk("t3_no_wait", 32'(n), 32'd0);
      wait_ack("t3_ack", lat);
      chk("t3_latency", 32'(lat), 32'd3);
      chk("t3_rdata",   32'(m_wb_dat_o), 32'hA005);
      chk("t3_swe",     32'(s_wb_we_o),  32'd0);
      wait_empty("t3_drain");

      // 4: push on the pop edge at count 2, order across pointer wrap
      s_wb_bsy_i = 1'b1;
      wr(15'h60, 2'b11, 16'h6000, n);
      wr(15'h61, 2'b11, 16'h6001, n);
      s_wb_bsy_i = 1'b0;
      @(posedge clk_i);
      #1;
      m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = 1'b1;
      m_wb_addr_i = 15'h62; m_wb_sel_i = 2'b11; m_wb_dat_i = 16'h6002;
      @(negedge clk_i);
      chk("t4_push_ok", 32'(m_wb_bsy_o), 32'd0);
      @(posedge clk_i);
      #1;
      m_wb_cyc_i = 1'b0; m_wb_stb_i = 1'b0;
      s_wb_bsy_i = 1'b1;
      wr(15'h63, 2'b11, 16'h6003, n);
      chk("t4_third", 32'(n), 32'd0);
      wr(15'h64, 2'b11, 16'h6004, n);
      chk("t4_fourth", 32'(n), 32'd0);
      m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = 1'b1;
      m_wb_addr_i = 15'h65; m_wb_sel_i = 2'b11; m_wb_dat_i = 16'h6005;
      @(negedge clk_i);
      chk("t4_full", 32'(m_wb_bsy_o), 32'd1);
      @(posedge clk_i);
      #1 s_wb_bsy_i = 1'b0;
      wait_accept("t4_last", n);
      m_wb_cyc_i = 1'b0; m_wb_stb_i = 1'b0;
      wait_empty("t4_drain");
      L = log_addr.size();
      for (int i = 0; i < 6; i++)
         chk("t4_order", 32'(log_addr[L-6+i]), 32'h60 + 32'(i));

      // 5: reset while a write is in flight with three buffered
      s_wb_bsy_i = 1'b1;
      wr(15'h70, 2'b11, 16'h7000, n);
      wr(15'h71, 2'b11, 16'h7001, n);
      wr(15'h72, 2'b11, 16'h7002, n);
      L = log_addr.size();
      rst_i = 1'b0;
      #1;
      chk("t5_cyc_drop", 32'(s_wb_cyc_o), 32'd0);
      chk("t5_bsy",      32'(m_wb_bsy_o), 32'd1);
      repeat (3) @(posedge clk_i);
      #1 s_wb_bsy_i = 1'b0;
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      repeat (10) @(negedge clk_i);
      chk("t5_empty",    32'(empty_o), 32'd1);
      chk("t5_no_stale", 32'(log_addr.size()), 32'(L));
      @(posedge clk_i);
      #1;
      rd(15'h70, 2'b11, n);
      wait_ack("t5_ack", lat);
      chk("t5_rdata", 32'(m_wb_dat_o), 32'hA070);
      wait_empty("t5_drain");

      // 6: partial byte select, empty timing after final ack
      wr(15'h20, 2'b01, 16'h1234, n);
      seen = 1'b0;
      got  = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk_i);
         if (s_wb_cyc_o && !seen) begin
            seen = 1'b1;
            chk("t6_sel", 32'(s_wb_sel_o), 32'h1);
            chk("t6_we",  32'(s_wb_we_o),  32'd1);
         end
         if (s_wb_ack_i) begin
            chk("t6_empty_before", 32'(empty_o), 32'd0);
            @(negedge clk_i);
            chk("t6_empty_after",  32'(empty_o), 32'd1);
            got = 1'b1;
         end
      end
      if (!got) fail_now("t6_ack");
      @(posedge clk_i);
      #1;
      rd(15'h20, 2'b11, n);
      wait_ack("t6_rack", lat);
      chk("t6_rdata", 32'(m_wb_dat_o), 32'hA034);
      wait_empty("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
